// File: rtl/sprite_compositor_if.sv
// Pixel stream, sprite configuration, ROM address/data and composited output bundle
// for sprite_compositor. master = pixel source / ROM side, slave = compositor.
interface sprite_compositor_if #(
    parameter int unsigned N_SPR  = 4,
    parameter int unsigned SPR_AW = 12,
    parameter int unsigned BG_AW  = 17
);
    logic                    pix_valid;
    logic                    pix_sof;
    logic [9:0]              pix_x;
    logic [9:0]              pix_y;
    logic [10*N_SPR-1:0]     spr_x;
    logic [10*N_SPR-1:0]     spr_y;
    logic [N_SPR-1:0]        spr_en;
    logic [N_SPR-1:0]        spr_mirror;
    logic [SPR_AW*N_SPR-1:0] spr_addr;
    logic [12*N_SPR-1:0]     spr_data;
    logic [BG_AW-1:0]        bg_addr;
    logic [11:0]             bg_data;
    logic [11:0]             rgb_out;
    logic                    rgb_valid;
    logic [N_SPR-1:0]        col_hit;
    logic                    col_valid;

    modport master (
        output pix_valid, pix_sof, pix_x, pix_y, spr_x, spr_y, spr_en, spr_mirror,
               spr_data, bg_data,
        input  spr_addr, bg_addr, rgb_out, rgb_valid, col_hit, col_valid
    );

    modport slave (
        input  pix_valid, pix_sof, pix_x, pix_y, spr_x, spr_y, spr_en, spr_mirror,
               spr_data, bg_data,
        output spr_addr, bg_addr, rgb_out, rgb_valid, col_hit, col_valid
    );
endinterface

// File: rtl/sprite_compositor.sv
// Composites N_SPR prioritised sprites over a background ROM and flags ball/sprite overlap per frame.
// Optional macro SPRITE_BBOX_DEBUG_EN draws enabled sprite bounding-box borders in white.
module sprite_compositor #(
    parameter int unsigned N_SPR       = 4,
    parameter int unsigned SPR_W       = 64,
    parameter int unsigned SPR_H       = 64,
    parameter int unsigned SPR_AW      = 12,
    parameter int unsigned BG_W        = 320,
    parameter int unsigned BG_AW       = 17,
    parameter int unsigned ROM_LAT     = 1,
    parameter logic [11:0] TRANS_COLOR = 12'h0F0
) (
    input logic             clk,
    input logic             reset,
    sprite_compositor_if.slave bus
);
    localparam int unsigned CW = 11;
    localparam int unsigned PW = 12;

    logic [CW-1:0]            px, py;
    logic [N_SPR-1:0]         region_c;
    logic [SPR_AW*N_SPR-1:0]  addr_c;
    logic [BG_AW-1:0]         bg_addr_c;

    assign px = CW'(bus.pix_x);
    assign py = CW'(bus.pix_y);

    // Stage A: region test and ROM addressing, widened to 11 bits so sx+SPR_W never wraps
    always_comb begin
        logic [CW-1:0] sx, sy, dx, dy, col;
        region_c  = '0;
        addr_c    = '0;
        sx        = '0;
        sy        = '0;
        dx        = '0;
        dy        = '0;
        col       = '0;
        bg_addr_c = BG_AW'(bus.pix_y) * BG_AW'(BG_W) + BG_AW'(bus.pix_x);
        for (int i = 0; i < int'(N_SPR); i++) begin
            sx = CW'(bus.spr_x[10*i +: 10]);
            sy = CW'(bus.spr_y[10*i +: 10]);
            dx = px - sx;
            dy = py - sy;
            if (bus.spr_en[i] && px >= sx && px < sx + CW'(SPR_W) &&
                py >= sy && py < sy + CW'(SPR_H)) begin
                region_c[i] = 1'b1;
                col = bus.spr_mirror[i] ? CW'(SPR_W - 1) - dx : dx;
                addr_c[SPR_AW*i +: SPR_AW] = SPR_AW'(dy) * SPR_AW'(SPR_W) + SPR_AW'(col);
            end
        end
    end

    logic                    valid_a, sof_a;
    logic [N_SPR-1:0]        region_a;
    logic [SPR_AW*N_SPR-1:0] spr_addr_q;
    logic [BG_AW-1:0]        bg_addr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_a    <= 1'b0;
            sof_a      <= 1'b0;
            region_a   <= '0;
            spr_addr_q <= '0;
            bg_addr_q  <= '0;
        end else begin
            valid_a    <= bus.pix_valid;
            sof_a      <= bus.pix_valid & bus.pix_sof;
            region_a   <= region_c;
            spr_addr_q <= addr_c;
            bg_addr_q  <= bg_addr_c;
        end
    end

    // Delay line keeping pixel side-band in lockstep with ROM data
    logic             dl_valid  [ROM_LAT];
    logic             dl_sof    [ROM_LAT];
    logic [N_SPR-1:0] dl_region [ROM_LAT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < int'(ROM_LAT); k++) begin
                dl_valid[k]  <= 1'b0;
                dl_sof[k]    <= 1'b0;
                dl_region[k] <= '0;
            end
        end else begin
            dl_valid[0]  <= valid_a;
            dl_sof[0]    <= sof_a;
            dl_region[0] <= region_a;
            for (int k = 1; k < int'(ROM_LAT); k++) begin
                dl_valid[k]  <= dl_valid[k-1];
                dl_sof[k]    <= dl_sof[k-1];
                dl_region[k] <= dl_region[k-1];
            end
        end
    end

    logic             valid_d, sof_d;
    logic [N_SPR-1:0] region_d;
    logic [N_SPR-1:0] opaque_c;
    logic             dbg_c;

    assign valid_d  = dl_valid[ROM_LAT-1];
    assign sof_d    = dl_sof[ROM_LAT-1];
    assign region_d = dl_region[ROM_LAT-1];

    always_comb begin
        opaque_c = '0;
        for (int i = 0; i < int'(N_SPR); i++)
            opaque_c[i] = region_d[i] && (bus.spr_data[12*i +: 12] != TRANS_COLOR);
    end

`ifdef SPRITE_BBOX_DEBUG_EN
    logic [N_SPR-1:0] border_c, border_a;
    logic [N_SPR-1:0] dl_border [ROM_LAT];

    always_comb begin
        border_c = '0;
        for (int i = 0; i < int'(N_SPR); i++)
            border_c[i] = region_c[i] &&
                (px == CW'(bus.spr_x[10*i +: 10]) ||
                 px == CW'(bus.spr_x[10*i +: 10]) + CW'(SPR_W - 1) ||
                 py == CW'(bus.spr_y[10*i +: 10]) ||
                 py == CW'(bus.spr_y[10*i +: 10]) + CW'(SPR_H - 1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            border_a <= '0;
            for (int k = 0; k < int'(ROM_LAT); k++) dl_border[k] <= '0;
        end else begin
            border_a     <= border_c;
            dl_border[0] <= border_a;
            for (int k = 1; k < int'(ROM_LAT); k++) dl_border[k] <= dl_border[k-1];
        end
    end

    assign dbg_c = (opaque_c == '0) && (|dl_border[ROM_LAT-1]);
`else
    assign dbg_c = 1'b0;
`endif

    logic [PW-1:0]    pix_c;
    logic [N_SPR-1:0] hit_c;

    // Stage C: lowest-index opaque sprite wins; ball overlap per sprite
    always_comb begin
        pix_c = bus.bg_data;
        hit_c = '0;
        for (int i = int'(N_SPR) - 1; i >= 0; i--)
            if (opaque_c[i]) pix_c = bus.spr_data[12*i +: 12];
        if (dbg_c) pix_c = 12'hFFF;
        for (int i = 1; i < int'(N_SPR); i++)
            hit_c[i] = opaque_c[0] && opaque_c[i];
    end

    logic [PW-1:0]    rgb_q;
    logic             rgb_valid_q, col_valid_q;
    logic [N_SPR-1:0] acc, col_hit_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb_q       <= '0;
            rgb_valid_q <= 1'b0;
            acc         <= '0;
            col_hit_q   <= '0;
            col_valid_q <= 1'b0;
        end else begin
            rgb_q       <= pix_c;
            rgb_valid_q <= valid_d;
            col_valid_q <= 1'b0;
            if (valid_d) begin
                if (sof_d) begin
                    col_hit_q   <= acc;
                    col_valid_q <= 1'b1;
                    acc         <= hit_c;
                end else begin
                    acc <= acc | hit_c;
                end
            end
        end
    end

    assign bus.spr_addr  = spr_addr_q;
    assign bus.bg_addr   = bg_addr_q;
    assign bus.rgb_out   = rgb_q;
    assign bus.rgb_valid = rgb_valid_q;
    assign bus.col_hit   = col_hit_q;
    assign bus.col_valid = col_valid_q;
endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Parametrised successor to the single-screen renderer's layer mux. Composites N_SPR equal-size sprites over a background for a scaled pixel stream.
- Issues per-sprite and background ROM addresses and aligns the returned data through a fixed-latency pipeline.
- Detects per-frame opaque overlap between sprite 0 (ball) and every other sprite.
- Sits between vga_sync/coordinate scaling and the RGB output register.

Parameters:
- N_SPR, 4, number of sprites; index 0 = ball, lower index = higher priority.
- SPR_W, 64, sprite width in scaled pixels.
- SPR_H, 64, sprite height in scaled pixels.
- SPR_AW, 12, sprite ROM address width; must satisfy 2^SPR_AW >= SPR_W*SPR_H.
- BG_W, 320, background width.
- BG_AW, 17, background ROM address width.
- ROM_LAT, 1, ROM read latency in cycles (1..4).
- TRANS_COLOR, 12'h0F0, sprite transparent key.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  pixel coordinate valid this cycle
- pix_sof  in  1  first pixel of frame; honoured only with pix_valid
- pix_x  in  10  scaled x
- pix_y  in  10  scaled y
- spr_x  in  10*N_SPR  sprite left edges, packed, sprite i at [10i+9:10i]
- spr_y  in  10*N_SPR  sprite top edges, packed the same way
- spr_en  in  N_SPR  sprite enable
- spr_mirror  in  N_SPR  horizontal mirror
- spr_addr  out  SPR_AW*N_SPR  sprite ROM addresses
- spr_data  in  12*N_SPR  sprite ROM data, valid ROM_LAT cycles after spr_addr
- bg_addr  out  BG_AW  background ROM address
- bg_data  in  12  background ROM data, same ROM_LAT
- rgb_out  out  12  composited pixel
- rgb_valid  out  1  rgb_out valid
- col_hit  out  N_SPR  last completed frame's overlap flags; bit 0 always 0
- col_valid  out  1  one-cycle pulse when col_hit updates

Behaviour:
- Reset: all outputs 0. Pipeline valids, accumulators and col_hit are cleared.
- Stage A (1 cycle after pix_valid):
  - Register bg_addr = pix_y*BG_W + pix_x.
  - Region test for sprite i: spr_en[i] && x in [sx, sx+SPR_W) && y in [sy, sy+SPR_H), computed in 11-bit arithmetic so there is no wrap at 1023.
  - spr_addr_i = (y-sy)*SPR_W + (mirror ? SPR_W-1-(x-sx) : x-sx).
  - spr_addr_i = 0 outside the region.
- Delay line: region flags, valid and sof travel through a ROM_LAT-deep shift register in lockstep with the ROM data.
- Stage C (registered):
  - opaque_i = region_i && spr_data_i != TRANS_COLOR.
  - rgb_out = data of the lowest-index opaque sprite, else bg_data.
  - rgb_valid = delayed pix_valid.
- Total latency, pix_valid to rgb_valid: ROM_LAT+2 cycles. Throughput is one pixel per cycle; gaps in pix_valid propagate as gaps.
- Collision:
  - acc[i] (i>=1) sets when an aligned valid pixel has opaque_0 && opaque_i. It is sticky within the frame.
  - When the delayed sof reaches Stage C: col_hit <= acc, col_valid = 1 for one cycle, and acc restarts with that pixel's own overlap result.
  - A first sof after reset publishes zeros.
- Disabled sprites are never in region, never drawn and never hit.
- Changes to spr_x/spr_y mid-frame are applied at the next pixel; no internal latching.
- pix_sof without pix_valid is ignored.
- Reset mid-frame: in-flight pixels are dropped; the next valid output appears ROM_LAT+2 cycles after the next pix_valid.

Optional Feature:
- Macro: SPRITE_BBOX_DEBUG_EN.
- When defined: pixels on the outer 1-pixel border of any enabled sprite region with no opaque sprite at that position are drawn 12'hFFF instead of background. Collision logic is unchanged.
- When undefined: no border logic is present and output is identical to the base behaviour.

Test Plan:
- Single pixel (ROM_LAT=1): pixel at (10,10), no sprites, bg_data=12'h123 -> bg_addr=3210; rgb_out=12'h123 with rgb_valid 3 cycles after pix_valid.
- Sprite 1 at (100,50), mirror=0, pixel (101,52) -> spr_addr_1=129. Same with mirror=1 -> spr_addr_1=190. Data 12'hABC -> rgb_out=12'hABC.
- Priority: sprites 0 and 2 both opaque at one pixel -> sprite 0 colour. Sprite 0 data=12'h0F0 -> sprite 2 colour.
- Edge wrap: spr_x=1000, pixel x=5 -> not in region; addr 0; bg shown.
- Collision: sprites 0 and 1 opaque overlap in frame 1, sprites 0 and 3 in frame 2 -> at the sofs that start frames 2 and 3, col_hit=4'b0010 then 4'b1000, each with a single col_valid pulse.
- Assert reset mid-frame with a pixel in flight -> rgb_valid and col_hit go 0 immediately and no stale pixel emerges after release.
